// File: rtl/dmux_sched_pkg.sv
// Shared constants, source naming and grant record for the
// EU result-return read scheduler.
package dmux_pkg;

    localparam int NSRC_D    = 6;
    localparam int AGE_W_D   = 4;
    localparam int AGE_LIM_D = 12;
    localparam int CNT_W_D   = 16;
    localparam int SEL_W_D   = $clog2(NSRC_D);

    typedef enum logic [2:0] {
        SRC_V,
        SRC_D,
        SRC_NET,
        SRC_STREAM,
        SRC_LOCAL,
        SRC_AUX
    } src_e;

    typedef struct packed {
        logic               vld;
        logic [SEL_W_D-1:0] sel;
        logic               urg;
    } grant_t;

endpackage

// File: rtl/dmux_sched_if.sv
// Request/grant/result bundle between the return FIFOs, the EU
// and the read scheduler.
interface dmux_if
    import dmux_pkg::*;
#(
    parameter int N  = NSRC_D,
    parameter int CW = CNT_W_D
) ();

    logic [N-1:0]         REQ;
    logic                 STALL;
    logic                 STAT_CLR;
    logic [N-1:0]         GNT;
    logic                 VLD;
    logic [$clog2(N)-1:0] SEL;
    logic                 URG;
    logic [CW-1:0]        URG_CNT;

    modport master (
        output REQ, STALL, STAT_CLR,
        input  GNT, VLD, SEL, URG, URG_CNT
    );

    modport slave (
        input  REQ, STALL, STAT_CLR,
        output GNT, VLD, SEL, URG, URG_CNT
    );

endinterface

// File: rtl/dmux_sched_rr_pick.sv
// First set bit of a vector at or after a start pointer, wrapping.
// Pointer 0 gives plain lowest-index priority.
module rr_pick #(
    parameter int N = 6,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] i_vec,
    input  logic [W-1:0] i_ptr,
    output logic [N-1:0] o_onehot,
    output logic [W-1:0] o_idx,
    output logic         o_any
);

    logic [W:0] w_pos;

    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        w_pos    = '0;
        for (int k = 0; k < N; k++) begin
            w_pos = {1'b0, i_ptr} + (W+1)'(k);
            if (w_pos >= (W+1)'(N)) begin
                w_pos = w_pos - (W+1)'(N);
            end
            if (!o_any && i_vec[w_pos[W-1:0]]) begin
                o_any              = 1'b1;
                o_onehot[w_pos[W-1:0]] = 1'b1;
                o_idx              = w_pos[W-1:0];
            end
        end
    end

endmodule

// File: rtl/dmux_sched.sv
// Return-mux read scheduler: fixed priority with aging promotion
// to a round-robin urgent class, registered steering outputs.
module dmux_sched
    import dmux_pkg::*;
#(
    parameter int NSrc     = NSRC_D,
    parameter int AgeWidth = AGE_W_D,
    parameter int AgeLimit = AGE_LIM_D,
    parameter int CntWidth = CNT_W_D
) (
    input logic  CLK,
    input logic  RESET,
    dmux_if.slave bus
);

    localparam int SelW = $clog2(NSrc);

    logic [AgeWidth-1:0] r_age [NSrc];
    logic [SelW-1:0]     r_ptr;
    logic [CntWidth-1:0] r_cnt;
    grant_t              r_out;

    logic [NSrc-1:0] w_urg_vec;
    logic [NSrc-1:0] w_urg_oh;
    logic [NSrc-1:0] w_fix_oh;
    logic [SelW-1:0] w_urg_idx;
    logic [SelW-1:0] w_fix_idx;
    logic            w_urg_any;
    logic            w_fix_any;
    logic            w_en;
    logic [NSrc-1:0] w_gnt;
    logic [SelW-1:0] w_idx;
    logic            w_any;
    logic            w_urg_gnt;

    always_comb begin
        for (int i = 0; i < NSrc; i++) begin
            w_urg_vec[i] = bus.REQ[i] &&
                (r_age[i] == AgeWidth'(AgeLimit));
        end
    end

    rr_pick #(.N(NSrc), .W(SelW)) u_urg (
        .i_vec    (w_urg_vec),
        .i_ptr    (r_ptr),
        .o_onehot (w_urg_oh),
        .o_idx    (w_urg_idx),
        .o_any    (w_urg_any)
    );

    rr_pick #(.N(NSrc), .W(SelW)) u_fix (
        .i_vec    (bus.REQ),
        .i_ptr    ('0),
        .o_onehot (w_fix_oh),
        .o_idx    (w_fix_idx),
        .o_any    (w_fix_any)
    );

    always_comb begin
        w_en      = !RESET && !bus.STALL;
        w_gnt     = '0;
        w_idx     = w_fix_idx;
        w_urg_gnt = 1'b0;
        if (w_en && w_urg_any) begin
            w_gnt     = w_urg_oh;
            w_idx     = w_urg_idx;
            w_urg_gnt = 1'b1;
        end else if (w_en && w_fix_any) begin
            w_gnt = w_fix_oh;
        end
        w_any = |w_gnt;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < NSrc; i++) begin
                r_age[i] <= '0;
            end
            r_ptr <= '0;
            r_cnt <= '0;
            r_out <= '0;
        end else begin
            r_out.vld <= w_any;
            r_out.urg <= w_urg_gnt;
            if (w_any) begin
                r_out.sel <= SEL_W_D'(w_idx);
            end
            if (!bus.STALL) begin
                for (int i = 0; i < NSrc; i++) begin
                    if (w_gnt[i] || !bus.REQ[i]) begin
                        r_age[i] <= '0;
                    end else if (r_age[i] != AgeWidth'(AgeLimit)) begin
                        r_age[i] <= r_age[i] + 1'b1;
                    end
                end
                if (w_urg_gnt) begin
                    r_ptr <= (w_idx == SelW'(NSrc-1)) ?
                        '0 : w_idx + 1'b1;
                end
            end
            // Clear wins over saturation; a coincident urgent grant counts as one.
            if (bus.STAT_CLR) begin
                r_cnt <= w_urg_gnt ? CntWidth'(1) : '0;
            end else if (w_urg_gnt && r_cnt != '1) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            assert ($onehot0(w_gnt));
            assert ((w_gnt & ~bus.REQ) == '0);
        end
    end

    assign bus.GNT     = w_gnt;
    assign bus.VLD     = r_out.vld;
    assign bus.SEL     = SelW'(r_out.sel);
    assign bus.URG     = r_out.urg;
    assign bus.URG_CNT = r_cnt;

endmodule

// File: tb/tb_dmux_sched.sv
// Randomised scoreboard bench for dmux_sched against a
// rule-level reference model.
`timescale 1ns/100ps
module tb_dmux_sched;
    import dmux_pkg::*;

    localparam int N   = 6;
    localparam int CW  = 8;
    localparam int LIM = 12;

    typedef struct {
        bit vld;
        int sel;
        bit urg;
        int cnt;
    } exp_t;

    logic CLK   = 1'b0;
    logic RESET = 1'b1;

    always #5 CLK = ~CLK;

    dmux_if #(.N(N), .CW(CW)) bus ();

    dmux_sched #(
        .NSrc     (N),
        .AgeWidth (4),
        .AgeLimit (LIM),
        .CntWidth (CW)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    exp_t sb[$];
    exp_t me;
    int   checks;
    int   passes;
    int   age[N];
    int   wait_c[N];
    int   ptr;
    int   cnt;
    int   sel_h;
    int   cyc;
    int   max_wait;

    task automatic step(input logic [N-1:0] req, input bit stall,
                        input bit clr, input bit rst);
        logic [N-1:0] eg;
        bit           urg_any;
        int           gi;
        exp_t         e;
        @(posedge CLK);
        #2;
        bus.REQ      = req;
        bus.STALL    = stall;
        bus.STAT_CLR = clr;
        RESET        = rst;
        eg      = '0;
        gi      = -1;
        urg_any = 1'b0;
        if (!rst && !stall) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (ptr + k) % N;
                if (gi < 0 && req[j] && age[j] == LIM) gi = j;
            end
            urg_any = (gi >= 0);
            for (int i = 0; i < N; i++) begin
                if (gi < 0 && req[i]) gi = i;
            end
            if (gi >= 0) eg[gi] = 1'b1;
        end
        #1;
        checks++;
        if (bus.GNT === eg) passes++;
        else $display("FAIL gnt cyc=%0d got=%b exp=%b",
                      cyc, bus.GNT, eg);
        for (int i = 0; i < N; i++) begin
            if (rst) wait_c[i] = 0;
            else if (!stall) begin
                if (req[i] && !bus.GNT[i]) begin
                    wait_c[i]++;
                    if (wait_c[i] > max_wait) max_wait = wait_c[i];
                end else begin
                    wait_c[i] = 0;
                end
            end
        end
        if (rst) begin
            for (int i = 0; i < N; i++) age[i] = 0;
            ptr   = 0;
            cnt   = 0;
            sel_h = 0;
            e     = '{0, 0, 0, 0};
        end else begin
            if (!stall) begin
                for (int i = 0; i < N; i++) begin
                    if (i == gi || !req[i]) age[i] = 0;
                    else if (age[i] < LIM) age[i]++;
                end
                if (urg_any) ptr = (gi + 1) % N;
            end
            if (clr) cnt = urg_any ? 1 : 0;
            else if (urg_any && cnt < (1 << CW) - 1) cnt++;
            if (gi >= 0) sel_h = gi;
            e = '{gi >= 0, sel_h, urg_any, cnt};
        end
        sb.push_back(e);
        cyc++;
    endtask

    initial begin
        forever begin
            @(posedge CLK);
            #1;
            if (sb.size() > 0) begin
                me = sb.pop_front();
                checks++;
                if (bus.VLD === me.vld && bus.SEL === 3'(me.sel) &&
                    bus.URG === me.urg && bus.URG_CNT === CW'(me.cnt))
                    passes++;
                else
                    $display("FAIL regs vld/sel/urg/cnt got=%b/%0d/%b/%0d exp=%b/%0d/%b/%0d",
                             bus.VLD, bus.SEL, bus.URG, bus.URG_CNT,
                             me.vld, me.sel, me.urg, me.cnt);
            end
        end
    end

    initial begin
        bus.REQ      = '0;
        bus.STALL    = 1'b0;
        bus.STAT_CLR = 1'b0;
        step(6'h3F, 0, 0, 1);
        step(6'h3F, 0, 0, 1);
        step(6'h3F, 0, 0, 0);
        step(6'b010100, 0, 0, 0);
        step(6'b000000, 0, 0, 0);
        repeat (14) step(6'b100001, 0, 0, 0);
        repeat (3) step(6'b011000, 0, 0, 0);
        repeat (5) step(6'b000010, 1, 0, 0);
        step(6'b000010, 0, 0, 0);
        repeat (700) step(6'h3F, 0, 0, 0);
        #1;
        checks++;
        if (bus.URG_CNT === '1) passes++;
        else $display("FAIL cnt_sat got=%h exp=%h", bus.URG_CNT, 8'hFF);
        repeat (20) step(6'h3F, 0, 1, 0);
        repeat (3000) begin
            step(N'($urandom | $urandom),
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 49) == 0,
                 $urandom_range(0, 299) == 0);
        end
        step(6'b000000, 0, 0, 0);
        repeat (2) @(posedge CLK);
        #2;
        checks++;
        if (max_wait <= LIM + N) passes++;
        else $display("FAIL starve got=%0d exp<=%0d", max_wait, LIM + N);
        checks++;
        if (sb.size() == 0) passes++;
        else $display("FAIL sb_drain got=%0d exp=0", sb.size());
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
